// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the raster timing block.
//   - Default 640x480@60 timing constants (25 MHz pixel clock).
//   - Control bundle that travels down the pixel alignment pipeline.
//   - RGB444 field helpers for the 12-bit {r,g,b} pixel word.
package vga_pkg;

    localparam int VGA_H_VISIBLE   = 640;
    localparam int VGA_H_FRONT     = 16;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_BACK      = 48;
    localparam int VGA_V_VISIBLE   = 480;
    localparam int VGA_V_FRONT     = 10;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_BACK      = 33;
    localparam int VGA_PIXEL_DELAY = 2;

    // Everything that must stay cycle-aligned with the returning pixel data.
    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
    } raster_ctl_t;

    // Blanked, syncs deasserted (both syncs are active-low).
    localparam raster_ctl_t CTL_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

    function automatic logic [3:0] rgb_red(input logic [11:0] p);
        return p[11:8];
    endfunction

    function automatic logic [3:0] rgb_grn(input logic [11:0] p);
        return p[7:4];
    endfunction

    function automatic logic [3:0] rgb_blu(input logic [11:0] p);
        return p[3:0];
    endfunction

endpackage

// File: rtl/delay_line.sv
// delay_line: WIDTH-bit shift register DEPTH stages long with synchronous,
// active-high reset. Every stage loads RESET_VALUE while reset is high.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   d      in   WIDTH-bit input word
//   q      out  input word delayed by DEPTH clocks
module delay_line #(
    parameter int                 WIDTH       = 1,
    parameter int                 DEPTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VALUE;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator and output stage of the character
// display engine.
// Ports:
//   clk        in   pixel clock (25 MHz for 640x480@60)
//   reset      in   synchronous active-high reset
//   newline    out  one-cycle strobe on the first clock of each visible line
//   advance    out  high on every visible pixel clock
//   line       out  visible line / 2 (line-doubled), held through blanking
//   frame      out  one-cycle strobe at the start of vertical blank
//   pixel      in   RGB444 {r,g,b} from the pixel generator, valid
//                   PIXEL_DELAY clocks after the matching advance
//   vga_red/grn/blu  out  registered, blanked colour pins
//   vga_hsync  out  active-low hsync, aligned with the colour pins
//   vga_vsync  out  active-low vsync, aligned with the colour pins
// Horizontal order is blank-then-visible so newline leads the first advance
// by the whole horizontal blank; vertical order is visible-then-blank.
// PIXEL_DELAY must be in 1..4.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int PIXEL_DELAY = VGA_PIXEL_DELAY
) (
    input  logic        clk,
    input  logic        reset,
    output logic        newline,
    output logic        advance,
    output logic [7:0]  line,
    output logic        frame,
    input  logic [11:0] pixel,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_grn,
    output logic [3:0]  vga_blu,
    output logic        vga_hsync,
    output logic        vga_vsync
);

    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_VISIBLE;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_START  = HW'(H_BLANK);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          v_vis_next;
    logic          hsync_raster;
    logic          vsync_raster;
    raster_ctl_t   ctl;
    raster_ctl_t   ctl_aligned;

    always_comb begin
        h_next = hcount + 1'b1;
        v_next = vcount;
        if (hcount == H_LAST) begin
            h_next = '0;
            v_next = (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end
        v_vis_next = (v_next < V_VIS_END);
    end

    // Strobes are decoded from the next counter value so each register
    // describes the counter state it sits beside. Reset parks the counters
    // on the last position so the first free-running cycle is (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount       <= H_LAST;
            vcount       <= V_LAST;
            newline      <= 1'b0;
            advance      <= 1'b0;
            frame        <= 1'b0;
            line         <= '0;
            hsync_raster <= 1'b1;
            vsync_raster <= 1'b1;
        end else begin
            hcount       <= h_next;
            vcount       <= v_next;
            newline      <= (h_next == '0) && v_vis_next;
            advance      <= (h_next >= H_VIS_START) && v_vis_next;
            frame        <= (h_next == '0) && (v_next == V_VIS_END);
            hsync_raster <= !((h_next >= H_SYNC_START) && (h_next < H_SYNC_END));
            vsync_raster <= !((v_next >= V_SYNC_START) && (v_next < V_SYNC_END));
            // Only visible lines update it, so it holds the last value through blank.
            if (v_vis_next) begin
                line <= 8'(v_next >> 1);
            end
        end
    end

    assign ctl.active  = advance;
    assign ctl.hsync_n = hsync_raster;
    assign ctl.vsync_n = vsync_raster;

    // Delays blanking and syncs by the pixel generator's latency so they
    // meet the pixel word that belongs to the same raster position.
    delay_line #(
        .WIDTH       ($bits(raster_ctl_t)),
        .DEPTH       (PIXEL_DELAY),
        .RESET_VALUE (CTL_IDLE)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .d     (ctl),
        .q     (ctl_aligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_red   <= '0;
            vga_grn   <= '0;
            vga_blu   <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            vga_hsync <= ctl_aligned.hsync_n;
            vga_vsync <= ctl_aligned.vsync_n;
            if (ctl_aligned.active) begin
                vga_red <= rgb_red(pixel);
                vga_grn <= rgb_grn(pixel);
                vga_blu <= rgb_blu(pixel);
            end else begin
                vga_red <= '0;
                vga_grn <= '0;
                vga_blu <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing.
// Two instances run side by side from one clock, reset and pixel stream:
//   dut_a - default 640x480 timing, covers the first lines after each reset
//   dut_s - a shrunken raster (PIXEL_DELAY=3) so whole frames, vertical
//           blank, vsync and the frame strobe fit in a short run
// Expected outputs come from the raster position (cycles since reset
// release, taken modulo the frame) computed with plain arithmetic.
`timescale 1ns/1ps
module tb_vga_timing;

    localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33, A_PD = 2;
    localparam int S_HV = 40,  S_HF = 4,  S_HS = 8,  S_HB = 6;
    localparam int S_VV = 20,  S_VF = 3,  S_VS = 2,  S_VB = 4,  S_PD = 3;
    localparam int S_FRAME = (S_HF + S_HS + S_HB + S_HV) * (S_VV + S_VF + S_VS + S_VB);

    typedef struct packed {
        logic       newline;
        logic       advance;
        logic       frame;
        logic [7:0] line;
        logic [3:0] red;
        logic [3:0] grn;
        logic [3:0] blu;
        logic       hsync;
        logic       vsync;
    } obs_t;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, pd;
    } cfg_t;

    logic        clk;
    logic        reset;
    logic [11:0] pixel;

    logic       nl_a, adv_a, frm_a, hs_a, vs_a;
    logic [7:0] line_a;
    logic [3:0] red_a, grn_a, blu_a;
    logic       nl_s, adv_s, frm_s, hs_s, vs_s;
    logic [7:0] line_s;
    logic [3:0] red_s, grn_s, blu_s;

    obs_t act [2];

    int          n_total;
    int          n_bad;
    obs_t        sb_q [2][$];
    logic        rst_drv;
    logic [11:0] pix_drv;
    int          t;
    bit          finish_req;
    bit          final_done;
    bit          frame_armed;
    int          frame_checks;
    int          frame_gap;
    int          nl_cnt;
    int          adv_cnt;

    vga_timing #(
        .H_VISIBLE (A_HV), .H_FRONT (A_HF), .H_SYNC (A_HS), .H_BACK (A_HB),
        .V_VISIBLE (A_VV), .V_FRONT (A_VF), .V_SYNC (A_VS), .V_BACK (A_VB),
        .PIXEL_DELAY (A_PD)
    ) dut_a (
        .clk (clk), .reset (reset),
        .newline (nl_a), .advance (adv_a), .line (line_a), .frame (frm_a),
        .pixel (pixel),
        .vga_red (red_a), .vga_grn (grn_a), .vga_blu (blu_a),
        .vga_hsync (hs_a), .vga_vsync (vs_a)
    );

    vga_timing #(
        .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .PIXEL_DELAY (S_PD)
    ) dut_s (
        .clk (clk), .reset (reset),
        .newline (nl_s), .advance (adv_s), .line (line_s), .frame (frm_s),
        .pixel (pixel),
        .vga_red (red_s), .vga_grn (grn_s), .vga_blu (blu_s),
        .vga_hsync (hs_s), .vga_vsync (vs_s)
    );

    assign act[0] = {nl_a, adv_a, frm_a, line_a, red_a, grn_a, blu_a, hs_a, vs_a};
    assign act[1] = {nl_s, adv_s, frm_s, line_s, red_s, grn_s, blu_s, hs_s, vs_s};

    // 10 ns pixel clock; only the relative cycle count matters here.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cfg_t cfg_of(input int g);
        cfg_t c;
        if (g == 0) begin
            c.hv = A_HV; c.hf = A_HF; c.hs = A_HS; c.hb = A_HB;
            c.vv = A_VV; c.vf = A_VF; c.vs = A_VS; c.vb = A_VB; c.pd = A_PD;
        end else begin
            c.hv = S_HV; c.hf = S_HF; c.hs = S_HS; c.hb = S_HB;
            c.vv = S_VV; c.vf = S_VF; c.vs = S_VS; c.vb = S_VB; c.pd = S_PD;
        end
        return c;
    endfunction

    function automatic obs_t reset_obs();
        obs_t e;
        e = '0;
        e.hsync = 1'b1;
        e.vsync = 1'b1;
        return e;
    endfunction

    // Reference: cycle t after release sits at raster position t mod frame,
    // horizontal = pos mod line length, vertical = pos / line length. Pins
    // show the position PIXEL_DELAY+1 cycles earlier, coloured with the
    // pixel word presented on the previous cycle.
    function automatic obs_t model(input int g, input int tt, input logic [11:0] pix_prev);
        cfg_t c;
        obs_t e;
        int   hblank, htot, vtot, pos, h, v;
        c      = cfg_of(g);
        hblank = c.hf + c.hs + c.hb;
        htot   = hblank + c.hv;
        vtot   = c.vv + c.vf + c.vs + c.vb;
        e      = reset_obs();
        pos    = tt % (htot * vtot);
        h      = pos % htot;
        v      = pos / htot;
        e.newline = (h == 0) && (v < c.vv);
        e.advance = (h >= hblank) && (v < c.vv);
        e.frame   = (h == 0) && (v == c.vv);
        e.line    = 8'(((v < c.vv) ? v : c.vv - 1) / 2);
        if (tt >= c.pd + 1) begin
            pos = (tt - c.pd - 1) % (htot * vtot);
            h   = pos % htot;
            v   = pos / htot;
            e.hsync = !((h >= c.hf) && (h < c.hf + c.hs));
            e.vsync = !((v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vs));
            if ((h >= hblank) && (v < c.vv)) begin
                {e.red, e.grn, e.blu} = pix_prev;
            end
        end
        return e;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("nl=%0b adv=%0b frm=%0b line=%0d rgb=%h%h%h hs=%0b vs=%0b",
                         o.newline, o.advance, o.frame, o.line, o.red, o.grn, o.blu,
                         o.hsync, o.vsync);
    endfunction

    task automatic checkOutput(input int g, input obs_t expv, input obs_t got);
        n_total++;
        if (got !== expv) begin
            n_bad++;
            $display("[TB] FAIL %s at %0t: got {%s} want {%s}",
                     (g == 0) ? "outputs_640x480" : "outputs_scaled", $time, fmt(got), fmt(expv));
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("[TB] FAIL %s at %0t: got %0d want %0d", name, $time, got, want);
        end
    endtask

    // One pixel clock: on entering the cycle, queue what both DUTs should
    // show given the reset/pixel they just sampled, then drive new inputs.
    task automatic stepCycle(input logic rst_val, input logic [11:0] pix);
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            sb_q[g].push_back(rst_drv ? reset_obs() : model(g, t, pix_drv));
        end
        if (rst_drv) t = 0;
        else         t++;
        reset   = rst_val;
        rst_drv = rst_val;
        pixel   = pix;
        pix_drv = pix;
    endtask

    task automatic applyStimulus(input int cycles, input logic rst_val, input bit random_pix);
        for (int i = 0; i < cycles; i++) begin
            stepCycle(rst_val, random_pix ? 12'($urandom) : 12'hABC);
        end
    endtask

    // Stimulus: reset, free run past two scaled frames, a 3-cycle reset in
    // the middle of a visible line on both rasters, then run again with a
    // constant pixel followed by random pixels.
    initial begin
        n_total    = 0;
        n_bad      = 0;
        reset      = 1'b1;
        rst_drv    = 1'b1;
        pixel      = '0;
        pix_drv    = '0;
        t          = 0;
        finish_req = 1'b0;
        $display("[TB] starting vga_timing scoreboard run");
        applyStimulus(4, 1'b1, 1'b1);
        applyStimulus(3974, 1'b0, 1'b1);
        applyStimulus(3, 1'b1, 1'b1);
        applyStimulus(2000, 1'b0, 1'b0);
        applyStimulus(3000, 1'b0, 1'b1);
        @(negedge clk);
        finish_req = 1'b1;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Monitor: every cycle pop the expected word for each DUT and compare
    // away from the active edge. Also measure whole frames on the scaled
    // raster: strobe period, newline pulses and advance cycles per frame.
    always @(negedge clk) begin
        obs_t e;
        for (int g = 0; g < 2; g++) begin
            if (sb_q[g].size() != 0) begin
                e = sb_q[g].pop_front();
                checkOutput(g, e, act[g]);
            end
        end
        if (reset) begin
            frame_armed = 1'b0;
        end else begin
            if (act[1].frame) begin
                if (frame_armed) begin
                    checkCount("frame_period", frame_gap, S_FRAME);
                    checkCount("newlines_per_frame", nl_cnt, S_VV);
                    checkCount("advances_per_frame", adv_cnt, S_VV * S_HV);
                    frame_checks++;
                end
                frame_armed = 1'b1;
                frame_gap   = 0;
                nl_cnt      = 0;
                adv_cnt     = 0;
            end
            frame_gap++;
            nl_cnt  += int'(act[1].newline);
            adv_cnt += int'(act[1].advance);
        end
        if (finish_req && !final_done) begin
            final_done = 1'b1;
            checkCount("complete_frames_measured", (frame_checks >= 2) ? 1 : 0, 1);
        end
    end

    initial begin
        final_done   = 1'b0;
        frame_armed  = 1'b0;
        frame_checks = 0;
        frame_gap    = 0;
        nl_cnt       = 0;
        adv_cnt      = 0;
    end

endmodule
